// File: rtl/vec_mult_pkg.sv
// Shared defaults and helpers for the lane-parallel fixed-point vector multiplier.
package vec_mult_pkg;

    localparam int LANES_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int FRAC_DEF  = 8;
    localparam int LAT_DEF   = 3;

    // Low bit index of a lane inside a packed LANES*DW vector.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

    // Largest representable result for a DW-bit lane in the given mode.
    function automatic logic signed [63:0] sat_max(input int dw, input logic sgn);
        return sgn ? (64'sd1 <<< (dw - 1)) - 64'sd1 : (64'sd1 <<< dw) - 64'sd1;
    endfunction

    // Smallest representable result for a DW-bit lane in the given mode.
    function automatic logic signed [63:0] sat_min(input int dw, input logic sgn);
        return sgn ? -(64'sd1 <<< (dw - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/vec_mult_lane.sv
// One DW x DW lane: signed/unsigned multiply, LAT-stage CE-gated pipe, FRAC shift, wrap or clamp.
// Saturation and overflow flags are built only when VEC_MULT_PIPE_SAT_EN is defined.
module vec_mult_lane
    import vec_mult_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          sgn_in,
    input  logic          sgn_out,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          ovf
);

    // Two guard bits let one signed product cover both operand modes.
    localparam int PW = 2 * DW + 2;

    logic signed [DW:0]   a_ext;
    logic signed [DW:0]   b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] pipe_reg [LAT];
    logic signed [PW-1:0] shifted;

    assign a_ext   = $signed({sgn_in & a[DW-1], a});
    assign b_ext   = $signed({sgn_in & b[DW-1], b});
    assign prod    = PW'(a_ext) * PW'(b_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_reg[0] <= '0;
        end else if (ce) begin
            pipe_reg[0] <= prod;
        end
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_reg[gi] <= '0;
                end else if (ce) begin
                    pipe_reg[gi] <= pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    // Unsigned products are non-negative here, so >>> is also the logical shift.
    assign shifted = pipe_reg[LAT-1] >>> FRAC;

`ifdef VEC_MULT_PIPE_SAT_EN
    logic signed [PW-1:0] hi_lim;
    logic signed [PW-1:0] lo_lim;
    logic                 over_hi;
    logic                 under_lo;

    assign hi_lim   = PW'(sat_max(DW, sgn_out));
    assign lo_lim   = PW'(sat_min(DW, sgn_out));
    assign over_hi  = shifted > hi_lim;
    assign under_lo = shifted < lo_lim;
    assign ovf      = over_hi || under_lo;
    assign res      = over_hi  ? hi_lim[DW-1:0] :
                      under_lo ? lo_lim[DW-1:0] : shifted[DW-1:0];
`else
    logic unused_bits;

    assign unused_bits = ^{sgn_out, shifted[PW-1:DW]};
    assign res         = shifted[DW-1:0];
    assign ovf         = 1'b0;
`endif

endmodule

// File: rtl/vec_mult_pipe.sv
// Elastic LANES-wide fixed-point multiplier: valid/ready on both sides, global stall on backpressure.
// Optional saturation with per-lane overflow flags: define VEC_MULT_PIPE_SAT_EN.
module vec_mult_pipe
    import vec_mult_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
    input  logic [LANES*DW-1:0] in_veca,
    input  logic [LANES*DW-1:0] in_vecb,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [LANES-1:0]    out_ovf
);

    logic                valid_reg [LAT];
    logic                sgn_reg   [LAT];
    logic                advance;
    logic                accept;
    logic                sgn_g;
    logic [LANES*DW-1:0] veca_g;
    logic [LANES*DW-1:0] vecb_g;

    // Gating out_valid with rst keeps in-flight beats hidden during the reset cycle itself.
    assign out_valid = valid_reg[LAT-1] && !rst;
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance && !rst;
    assign accept    = in_valid && in_ready;

    // Bubbles carry zero operands so idle stages never show stale data.
    assign sgn_g  = accept & in_signed;
    assign veca_g = in_veca & {(LANES*DW){accept}};
    assign vecb_g = in_vecb & {(LANES*DW){accept}};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg[0] <= 1'b0;
            sgn_reg[0]   <= 1'b0;
        end else if (advance) begin
            valid_reg[0] <= accept;
            sgn_reg[0]   <= sgn_g;
        end
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_ctrl
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    sgn_reg[gi]   <= 1'b0;
                end else if (advance) begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    sgn_reg[gi]   <= sgn_reg[gi-1];
                end
            end
        end

        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            vec_mult_lane #(
                .DW   (DW),
                .FRAC (FRAC),
                .LAT  (LAT)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .ce      (advance),
                .sgn_in  (sgn_g),
                .sgn_out (sgn_reg[LAT-1]),
                .a       (veca_g[lane_lo(gi, DW) +: DW]),
                .b       (vecb_g[lane_lo(gi, DW) +: DW]),
                .res     (out_data[lane_lo(gi, DW) +: DW]),
                .ovf     (out_ovf[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_vec_mult_pipe.sv
// Scoreboard bench for vec_mult_pipe: directed vectors, stall/reset scenarios, random traffic.
module tb_vec_mult_pipe;

    localparam int LANES = 16;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int LAT   = 3;
    localparam int W     = LANES * DW;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [LANES-1:0] ovf;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [W-1:0]     in_veca;
    logic [W-1:0]     in_vecb;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [LANES-1:0] out_ovf;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errs   = 0;
    int    n_out    = 0;
    bit    rand_done;

    vec_mult_pipe #(
        .LANES (LANES),
        .DW    (DW),
        .FRAC  (FRAC),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_veca   (in_veca),
        .in_vecb   (in_vecb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, floor-shift, then range check in the beat's mode.
    function automatic beat_t ref_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        beat_t  r;
        longint sa, sb, sh, hi, lo;
        logic [DW-1:0] ea, eb;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            ea = a[i*DW +: DW];
            eb = b[i*DW +: DW];
            sa = sgn ? longint'($signed(ea)) : longint'(ea);
            sb = sgn ? longint'($signed(eb)) : longint'(eb);
            sh = (sa * sb) >>> FRAC;
            hi = sgn ? (64'sd1 <<< (DW - 1)) - 1 : (64'sd1 <<< DW) - 1;
            lo = sgn ? -(64'sd1 <<< (DW - 1)) : 0;
`ifdef VEC_MULT_PIPE_SAT_EN
            if (sh > hi) begin
                r.data[i*DW +: DW] = hi[DW-1:0];
                r.ovf[i] = 1'b1;
            end else if (sh < lo) begin
                r.data[i*DW +: DW] = lo[DW-1:0];
                r.ovf[i] = 1'b1;
            end else begin
                r.data[i*DW +: DW] = sh[DW-1:0];
            end
`else
            r.data[i*DW +: DW] = sh[DW-1:0];
`endif
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input beat_t exp);
        in_veca   = a;
        in_vecb   = b;
        in_signed = sgn;
        in_valid  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        n_errs++;
        $display("FAIL send_timeout: in_ready got 0 for 1000 cycles expected 1");
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input string name);
        int seen;
        seen = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = n;
                break;
            end
        end
        chk(name, W'(seen), W'(LAT));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk(name, W'(exp_q.size()), W'(0));
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall hold behaviour.
    initial begin
        bit           prev_stall;
        logic [W-1:0] prev_data;
        logic [LANES-1:0] prev_ovf;
        beat_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", W'(out_valid), W'(1));
                    chk("hold_data", out_data, prev_data);
                    chk("hold_ovf", W'(out_ovf), W'(prev_ovf));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_output: got data %h expected no beat", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("data_beat%0d", n_out), out_data, e.data);
                        chk($sformatf("ovf_beat%0d", n_out), W'(out_ovf), W'(e.ovf));
                    end
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_ovf   = out_ovf;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errs++;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        beat_t e;
        int base_out;

        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
        in_veca = '0; in_vecb = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_in_ready", W'(in_ready), W'(0));
        chk("reset_out_data", out_data, W'(0));
        chk("reset_out_ovf", W'(out_ovf), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", W'(in_ready), W'(1));
        @(posedge clk); #1;

        // Lane 0 unsigned 2.0 x 3.0
        a = '0; b = '0; e = '0;
        a[15:0] = 16'h0200; b[15:0] = 16'h0300; e.data[15:0] = 16'h0600;
        send(a, b, 1'b0, e);
        check_latency("latency_first");

        // Lane 5 signed -1.0 x 2.0
        a = '0; b = '0; e = '0;
        a[5*DW +: DW] = 16'hFF00; b[5*DW +: DW] = 16'h0200; e.data[5*DW +: DW] = 16'hFE00;
        send(a, b, 1'b1, e);
        // Same operands unsigned overflow
        e = '0;
`ifdef VEC_MULT_PIPE_SAT_EN
        e.data[5*DW +: DW] = 16'hFFFF; e.ovf[5] = 1'b1;
`else
        e.data[5*DW +: DW] = 16'hFE00;
`endif
        send(a, b, 1'b0, e);
        // All lanes signed 0x7F00 squared
        for (int i = 0; i < LANES; i++) begin
            a[i*DW +: DW] = 16'h7F00;
`ifdef VEC_MULT_PIPE_SAT_EN
            e.data[i*DW +: DW] = 16'h7FFF;
            e.ovf[i] = 1'b1;
`else
            e.data[i*DW +: DW] = 16'h0100;
            e.ovf[i] = 1'b0;
`endif
        end
        send(a, a, 1'b1, e);
        drain("drain_directed");

        // Stream 20 beats with backpressure in cycles 6..10
        base_out = n_out;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    e = '0;
                    for (int i = 0; i < LANES; i++) begin
                        a[i*DW +: DW] = DW'((k << 8) + i);
                        b[i*DW +: DW] = 16'h0100;
                        e.data[i*DW +: DW] = DW'((k << 8) + i);
                    end
                    send(a, b, 1'b0, e);
                end
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    out_ready = !(k >= 6 && k <= 10);
                    @(negedge clk);
                    chk($sformatf("stall_in_ready_k%0d", k), W'(in_ready), W'(!(k >= 6 && k <= 10)));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        chk("stall_count", W'(n_out - base_out), W'(20));

        // Reset with three beats in flight
        base_out = n_out;
        for (int k = 0; k < 3; k++) begin
            a = rand_vec(); b = rand_vec();
            send(a, b, 1'b1, ref_beat(a, b, 1'b1));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("flush_out_valid_rst", W'(out_valid), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("flush_out_valid_c%0d", k), W'(out_valid), W'(0));
        end
        @(posedge clk); #1;
        chk("flush_count", W'(n_out - base_out), W'(0));
        a = '0; b = '0; e = '0;
        a[15:0] = 16'h0200; b[15:0] = 16'h0300; e.data[15:0] = 16'h0600;
        send(a, b, 1'b0, e);
        check_latency("latency_after_rst");
        drain("drain_flush");

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                logic s;
                for (int k = 0; k < 10000; k++) begin
                    while ($urandom_range(0, 99) < 30) begin
                        @(posedge clk); #1;
                    end
                    a = rand_vec(); b = rand_vec(); s = 1'($urandom_range(0, 1));
                    send(a, b, s, ref_beat(a, b, s));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 99) < 70);
                    @(posedge clk); #1;
                end
            end
        join
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
